// File: rtl/logicnet_layer_pipe_reg.sv
// logicnet_layer_pipe_reg: elastic two-entry skid buffer between LogicNet layers.
// Captures one layer's packed neuron outputs and presents them to the next
// layer. s_ready is a flop so upstream LUT timing never sees m_ready.
module logicnet_layer_pipe_reg #(
  parameter int WIDTH = 256,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             in_evt, out_evt;
  logic             ld_main_s, ld_main_skid, ld_skid;

  assign m_valid   = (state != EMPTY);
  assign m_data    = main_q;
  // State encoding equals the number of vectors held.
  assign occupancy = state;
  assign in_evt    = s_valid & s_ready;
  assign out_evt   = m_valid & m_ready;

  // Next state and register load selects; flush overrides every event.
  always_comb begin
    state_nxt    = state;
    ld_main_s    = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_evt) begin
          state_nxt = ONE;
          ld_main_s = 1'b1;
        end
        ONE: begin
          if (in_evt && out_evt) begin
            ld_main_s = 1'b1;
          end else if (in_evt) begin
            ld_skid   = 1'b1;
            state_nxt = FULL;
          end else if (out_evt) begin
            state_nxt = EMPTY;
          end
        end
        FULL: if (out_evt) begin
          // Skid always holds the younger vector, so it moves to main.
          ld_main_skid = 1'b1;
          state_nxt    = ONE;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // State, registered ready and data storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      s_ready <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state   <= state_nxt;
      s_ready <= (state_nxt != FULL);
      if (ld_main_s)         main_q <= s_data;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= s_data;
    end
  end

  // Saturating count of downstream stall cycles; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= '0;
    else if (m_valid && !m_ready && (stall_count != {CNT_W{1'b1}}))
      stall_count <= stall_count + 1'b1;
  end

endmodule

// File: tb/tb_logicnet_layer_pipe_reg.sv
// Bench for logicnet_layer_pipe_reg: queue-based reference model, per-cycle
// compare, directed scenarios with literal expectations, then random traffic.
// A second narrow instance (WIDTH=8, CNT_W=4) shares the controls to exercise
// stall counter saturation.
module tb_logicnet_layer_pipe_reg;
  localparam int W = 256;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0, m_ready = 1'b0, flush = 1'b0;
  logic [W-1:0] s_data = '0;
  logic         s_ready, m_valid;
  logic [W-1:0] m_data;
  logic [1:0]   occupancy;
  logic [15:0]  stall_count;
  logic         n_s_ready, n_m_valid;
  logic [7:0]   n_m_data;
  logic [1:0]   n_occupancy;
  logic [3:0]   n_stall_count;

  int pass_cnt = 0, total = 0;

  always #5 clk = ~clk;

  logicnet_layer_pipe_reg #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .flush(flush),
    .occupancy(occupancy), .stall_count(stall_count));

  logicnet_layer_pipe_reg #(.WIDTH(8), .CNT_W(4)) dut_n (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(n_s_ready), .s_data(s_data[7:0]),
    .m_valid(n_m_valid), .m_ready(m_ready), .m_data(n_m_data), .flush(flush),
    .occupancy(n_occupancy), .stall_count(n_stall_count));

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else pass_cnt++;
  endtask

  // Reference model: a FIFO of at most two vectors plus a registered ready.
  logic [W-1:0] q[$];
  logic         m_sr;
  int           m_stall, m_stall4;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_sr     = 1'b0;
      m_stall  = 0;
      m_stall4 = 0;
    end else begin
      automatic bit acc = s_valid && m_sr;
      automatic bit dep = (q.size() > 0) && m_ready;
      if (q.size() > 0 && !m_ready) begin
        if (m_stall < 65535) m_stall++;
        if (m_stall4 < 15) m_stall4++;
      end
      if (flush) q.delete();
      else begin
        if (dep) void'(q.pop_front());
        if (acc) q.push_back(s_data);
      end
      m_sr = (q.size() != 2);
    end
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    chk("m_valid", W'(m_valid), W'(q.size() > 0));
    chk("s_ready", W'(s_ready), W'(m_sr));
    chk("occupancy", W'(occupancy), W'(q.size()));
    chk("stall_count", W'(stall_count), W'(m_stall));
    chk("n_m_valid", W'(n_m_valid), W'(q.size() > 0));
    chk("n_s_ready", W'(n_s_ready), W'(m_sr));
    chk("n_occupancy", W'(n_occupancy), W'(q.size()));
    chk("n_stall_count", W'(n_stall_count), W'(m_stall4));
    if (q.size() > 0) begin
      chk("m_data", m_data, q[0]);
      chk("n_m_data", W'(n_m_data), W'(q[0][7:0]));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [W-1:0] VA = {64{4'hA}};
  localparam logic [W-1:0] VB = {64{4'h5}};

  initial begin
    // Reset and release.
    cycle(); cycle();
    chk("rst_m_valid", W'(m_valid), '0);
    chk("rst_s_ready", W'(s_ready), '0);
    chk("rst_m_data", m_data, '0);
    rst = 1'b0;
    chk("rel_s_ready_before_edge", W'(s_ready), '0);
    cycle();
    chk("rel_s_ready_after_edge", W'(s_ready), W'(1));

    // Streaming with m_ready high: one vector per cycle, occupancy 1.
    m_ready = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      s_valid = 1'b1; s_data = W'(k);
      cycle();
      chk("stream_data", m_data, W'(k));
      chk("stream_occ", W'(occupancy), W'(1));
    end
    s_valid = 1'b0;
    cycle();
    chk("stream_drained", W'(m_valid), '0);

    // Backpressure: A then B with m_ready low.
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = VA; cycle();
    s_data = VB; cycle();
    s_valid = 1'b0;
    chk("bp_occ", W'(occupancy), W'(2));
    chk("bp_s_ready", W'(s_ready), '0);
    chk("bp_data_a", m_data, VA);
    chk("bp_stall1", W'(stall_count), W'(1));
    cycle();
    chk("bp_stall2", W'(stall_count), W'(2));
    cycle();
    chk("bp_stall3", W'(stall_count), W'(3));
    chk("bp_data_a_held", m_data, VA);
    m_ready = 1'b1;
    cycle();
    chk("bp_data_b", m_data, VB);
    chk("bp_s_ready_back", W'(s_ready), W'(1));
    cycle();
    chk("bp_empty", W'(occupancy), '0);
    chk("bp_stall_kept", W'(stall_count), W'(3));

    // Simultaneous in/out in ONE.
    s_valid = 1'b1; s_data = W'(256'h1234); cycle();
    s_data = W'(256'hC0FFEE); cycle();
    chk("sim_data_c", m_data, W'(256'hC0FFEE));
    chk("sim_occ", W'(occupancy), W'(1));
    s_valid = 1'b0; cycle();

    // Flush from FULL with simultaneous in and out.
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = W'(8'h11); cycle();
    s_data = W'(8'h22); cycle();
    chk("fl_full", W'(occupancy), W'(2));
    flush = 1'b1; s_data = W'(8'h33); m_ready = 1'b1; cycle();
    flush = 1'b0; s_valid = 1'b0;
    chk("fl_m_valid", W'(m_valid), '0);
    chk("fl_occ", W'(occupancy), '0);
    chk("fl_s_ready", W'(s_ready), W'(1));
    chk("fl_stall_kept", W'(stall_count), W'(4));
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("fl_dropped", W'(m_valid), '0);
    end

    // Saturation of the narrow counter over a 20-cycle stall.
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = W'(8'h44); cycle();
    s_valid = 1'b0;
    repeat (20) cycle();
    chk("sat_narrow", W'(n_stall_count), W'(15));
    chk("sat_wide", W'(stall_count), W'(24));
    m_ready = 1'b1; cycle();

    // Reset asserted with two vectors held.
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = VA; cycle();
    s_data = VB; cycle();
    s_valid = 1'b0;
    chk("mid_full", W'(occupancy), W'(2));
    rst = 1'b1;
    #1;
    chk("mid_rst_m_valid", W'(m_valid), '0);
    chk("mid_rst_s_ready", W'(s_ready), '0);
    chk("mid_rst_occ", W'(occupancy), '0);
    chk("mid_rst_stall", W'(stall_count), '0);
    chk("mid_rst_data", m_data, '0);
    cycle();
    rst = 1'b0;
    chk("mid_rel_s_ready0", W'(s_ready), '0);
    cycle();
    chk("mid_rel_s_ready1", W'(s_ready), W'(1));

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      s_valid = ($urandom_range(3) != 0);
      m_ready = ($urandom_range(2) != 0);
      flush   = ($urandom_range(31) == 0);
      for (int j = 0; j < 8; j++) s_data[j*32 +: 32] = $urandom;
      cycle();
    end
    s_valid = 1'b0; flush = 1'b0; m_ready = 1'b1;
    cycle(); cycle();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/logicnet_layer_pipe_reg.md
# logicnet_layer_pipe_reg

Elastic pipeline register placed at every LogicNet layer boundary. It captures the packed 1-bit outputs of one layer's neuron LUTs, for example the layer-2 neuron bank, and presents them as the input vector of the next layer. A two-entry skid buffer with valid/ready handshake sustains one vector per cycle, and `s_ready` is fully registered. This breaks long LUT chains into clocked stages and lets downstream stalls propagate without dropping data.

## Interface
- `WIDTH`, default 256: bits per layer vector, one bit per neuron output.
- `CNT_W`, default 16: width of the stall counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `s_valid` in 1: upstream vector valid.
- `s_ready` out 1: block can accept a vector. Registered.
- `s_data` in WIDTH: packed neuron outputs of the upstream layer; bit i is neuron i.
- `m_valid` out 1: output vector valid.
- `m_ready` in 1: downstream layer accepts.
- `m_data` out WIDTH: vector presented to the downstream layer's LUT inputs.
- `flush` in 1: synchronous discard of all buffered vectors.
- `occupancy` out 2: number of vectors held (0, 1 or 2).
- `stall_count` out CNT_W: saturating count of cycles with `m_valid & ~m_ready`.

## Operation
- Storage:
  - main register drives `m_data`;
  - skid register holds the second vector.
- Handshake events:
  - in = `s_valid & s_ready`
  - out = `m_valid & m_ready`
- States: EMPTY (occupancy 0), ONE (1), FULL (2).
  - `m_valid` = (state != EMPTY).
  - `s_ready` is a register whose next value is (next_state != FULL).
- Transitions:
  - EMPTY:
    - in → main ← `s_data`, go to ONE;
    - otherwise stay.
  - ONE:
    - in & out → main ← `s_data`, stay ONE;
    - in & ~out → skid ← `s_data`, go to FULL;
    - ~in & out → EMPTY;
    - neither → hold.
  - FULL:
    - out → main ← skid, go to ONE;
    - otherwise hold. No in is possible because `s_ready` is 0.
- Order is strictly preserved: a vector in skid always leaves after the one in main.
- `m_data` changes only on an out event or an EMPTY→ONE load. It never changes while `m_valid & ~m_ready`.
- `flush` has priority over every other event:
  - next state EMPTY, next `s_ready` = 1;
  - a simultaneous in or out is ignored (the vector is dropped);
  - register data contents are don't-care after flush.
- `stall_count`:
  - increments by 1 each cycle `m_valid & ~m_ready` holds, flush cycles included;
  - saturates at 2^CNT_W−1;
  - cleared only by `rst`, not by `flush`.
- Data is passed bit-exact; no arithmetic on `s_data`.

## Timing
- Reset (asynchronous, immediate while `rst` is high):
  - state EMPTY, `m_valid` 0, `s_ready` 0;
  - main 0, skid 0, `m_data` 0;
  - `occupancy` 0, `stall_count` 0.
- First rising edge after `rst` falls: `s_ready` becomes 1. No vector is accepted in that cycle.
- Latency: a vector accepted at edge N is on `m_data` with `m_valid` 1 after edge N; it can be consumed at edge N+1.
- Throughput: 1 vector/cycle with `m_ready` held high; no bubbles.
- `s_ready` has no combinational path from `m_ready`, `s_valid` or `flush`.
  - After the edge that fills the skid, `s_ready` is 0.
  - It returns to 1 on the edge following the first out event in FULL.
- Reset asserted mid-transfer: buffered vectors are lost and outputs go to reset values immediately. Upstream must re-present.

## Test plan
- Reset/idle:
  - assert `rst` mid-stream with occupancy 2 → `m_valid`, `s_ready`, `occupancy`, `stall_count` read 0 asynchronously;
  - after release, `s_ready` = 1 one edge later.
- Streaming: `m_ready`=1, push vectors 0x01, 0x02, …, 0x40 (WIDTH=256, zero-extended) on consecutive cycles → identical sequence on `m_data`, one cycle later, no gaps, `occupancy` constantly 1.
- Backpressure:
  - push A=0xAAAA…, B=0x5555… with `m_ready`=0 → occupancy 2, `s_ready` 0, `m_data`=A held;
  - `stall_count` increments each cycle;
  - raise `m_ready` → A then B delivered on consecutive cycles;
  - `s_ready` 1 one edge after A leaves.
- Simultaneous in/out in ONE: hold occupancy 1 while offering C with `m_ready`=1 → C replaces the departing vector and occupancy stays 1.
- Flush:
  - in FULL, assert `flush` together with `s_valid` and `m_ready` → next cycle `m_valid` 0, `occupancy` 0, `s_ready` 1;
  - the offered vector is not emitted;
  - `stall_count` is not cleared.
- Saturation: with CNT_W=4, stall for 20 cycles → `stall_count` stops at 15.
